// File: rtl/fft_pair_ram_if.sv
// Bus bundle for fft_pair_ram: host word port, sequencer control,
// operand-pair issue port and butterfly write-back port.
interface fft_pair_ram_if #(
  parameter int WIDTH  = 16,
  parameter int LOG2_N = 6
);
  localparam int SW = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;

  logic              host_en;
  logic              host_we;
  logic [LOG2_N-1:0] host_addr;
  logic [WIDTH-1:0]  host_wdata;
  logic [WIDTH-1:0]  host_rdata;
  logic              host_rvalid;

  logic              start;
  logic              busy;
  logic              done;

  logic              rd_valid;
  logic              rd_ready;
  logic [SW-1:0]     rd_stage;
  logic [LOG2_N-1:0] rd_addr_a;
  logic [LOG2_N-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_a;
  logic [WIDTH-1:0]  rd_data_b;

  logic              wb_valid;
  logic [LOG2_N-1:0] wb_addr_a;
  logic [LOG2_N-1:0] wb_addr_b;
  logic [WIDTH-1:0]  wb_data_a;
  logic [WIDTH-1:0]  wb_data_b;

  modport slave (
    input  host_en, host_we, host_addr, host_wdata,
    output host_rdata, host_rvalid,
    input  start,
    output busy, done,
    output rd_valid, rd_stage, rd_addr_a, rd_addr_b, rd_data_a, rd_data_b,
    input  rd_ready,
    input  wb_valid, wb_addr_a, wb_addr_b, wb_data_a, wb_data_b
  );

  modport master (
    output host_en, host_we, host_addr, host_wdata,
    input  host_rdata, host_rvalid,
    output start,
    input  busy, done,
    input  rd_valid, rd_stage, rd_addr_a, rd_addr_b, rd_data_a, rd_data_b,
    output rd_ready,
    output wb_valid, wb_addr_a, wb_addr_b, wb_data_a, wb_data_b
  );
endinterface

// File: rtl/fft_pair_ram.sv
// Flip-flop sample store with an in-place radix-2 butterfly pair sequencer.
// Optional BIT_REVERSE_LOAD_EN: host writes land at the bit-reversed address.
module fft_pair_ram #(
  parameter int WIDTH  = 16,
  parameter int LOG2_N = 6
) (
  input logic           clk,
  input logic           rst,
  fft_pair_ram_if.slave bus
);
  localparam int                N          = 1 << LOG2_N;
  localparam int                SW         = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;
  localparam logic [LOG2_N-1:0] HALF_N     = LOG2_N'(N / 2);
  localparam logic [SW-1:0]     LAST_STAGE = SW'(LOG2_N - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WB, DONE} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0]  mem [N];
  logic [SW-1:0]     stage;
  logic [LOG2_N-1:0] issue_k, wb_count;
  logic [LOG2_N-1:0] half, pair_a, pair_b, host_waddr;
  logic              all_issued, load_pair, issue_end, wb_beat, barrier_met;
  logic              busy, done;

  logic              rd_valid;
  logic [SW-1:0]     rd_stage;
  logic [LOG2_N-1:0] rd_addr_a, rd_addr_b;
  logic [WIDTH-1:0]  rd_data_a, rd_data_b, host_rdata;
  logic              host_rvalid;

`ifdef BIT_REVERSE_LOAD_EN
  always_comb begin
    host_waddr = '0;
    for (int i = 0; i < LOG2_N; i++) host_waddr[i] = bus.host_addr[LOG2_N-1-i];
  end
`else
  assign host_waddr = bus.host_addr;
`endif

  // Pair k: keep the low s bits of k, shift the rest up one to open the 'half' gap.
  always_comb begin
    half   = LOG2_N'(1) << stage;
    pair_a = (((issue_k >> stage) << stage) << 1) | (issue_k & (half - 1'b1));
    pair_b = pair_a + half;
  end

  assign all_issued  = (issue_k == HALF_N);
  assign load_pair   = (state == ISSUE) && !all_issued && (!rd_valid || bus.rd_ready);
  assign issue_end   = (state == ISSUE) && all_issued && (!rd_valid || bus.rd_ready);
  assign wb_beat     = ((state == ISSUE) || (state == WAIT_WB)) && bus.wb_valid && (wb_count != HALF_N);
  assign barrier_met = (wb_count == HALF_N) || (wb_beat && (wb_count == HALF_N - 1'b1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) state_next = ISSUE;
      end
      ISSUE:   if (issue_end) state_next = WAIT_WB;
      WAIT_WB: if (barrier_met) state_next = (stage == LAST_STAGE) ? DONE : ISSUE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage     <= '0;
      issue_k   <= '0;
      wb_count  <= '0;
      rd_valid  <= 1'b0;
      rd_stage  <= '0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      if (state == IDLE) begin
        stage    <= '0;
        issue_k  <= '0;
        wb_count <= '0;
      end
      if (load_pair) begin
        rd_valid  <= 1'b1;
        rd_stage  <= stage;
        rd_addr_a <= pair_a;
        rd_addr_b <= pair_b;
        rd_data_a <= mem[pair_a];
        rd_data_b <= mem[pair_b];
        issue_k   <= issue_k + 1'b1;
      end else if (issue_end) begin
        rd_valid <= 1'b0;
      end
      if (wb_beat) wb_count <= wb_count + 1'b1;
      // Barrier release: the whole stage is written back, so the next stage reads coherent data.
      if ((state == WAIT_WB) && barrier_met) begin
        wb_count <= '0;
        issue_k  <= '0;
        if (stage != LAST_STAGE) stage <= stage + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= 1'b0;
      if (!busy && bus.host_en) begin
        if (bus.host_we) begin
          mem[host_waddr] <= bus.host_wdata;
        end else begin
          host_rdata  <= mem[bus.host_addr];
          host_rvalid <= 1'b1;
        end
      end
      // Port b is written last so it wins when both addresses collide.
      if (busy && bus.wb_valid) begin
        mem[bus.wb_addr_a] <= bus.wb_data_a;
        mem[bus.wb_addr_b] <= bus.wb_data_b;
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.rd_valid    = rd_valid;
  assign bus.rd_stage    = rd_stage;
  assign bus.rd_addr_a   = rd_addr_a;
  assign bus.rd_addr_b   = rd_addr_b;
  assign bus.rd_data_a   = rd_data_a;
  assign bus.rd_data_b   = rd_data_b;
  assign bus.host_rdata  = host_rdata;
  assign bus.host_rvalid = host_rvalid;
endmodule

// File: tb/tb_fft_pair_ram.sv
// Scoreboard bench for fft_pair_ram (WIDTH=16, LOG2_N=3): expected host reads and
// operand pairs are queued by the stimulus, popped and compared by a monitor.
module tb_fft_pair_ram;
  localparam int WIDTH  = 16;
  localparam int LOG2_N = 3;

  typedef struct {
    logic [1:0]  stage;
    logic [2:0]  a, b;
    logic [15:0] da, db;
  } pair_t;

  typedef struct {
    logic [2:0]  a, b;
    logic [15:0] da, db;
    int          delay;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_pair_ram_if #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) bus ();
  fft_pair_ram #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) dut (.clk(clk), .rst(rst), .bus(bus));

  pair_t       pair_q[$];
  wb_t         wb_q[$];
  logic [15:0] host_q[$];
  logic [15:0] model[8];

  int checks = 0, failures = 0, done_count = 0;
  int beat_idx = 0, delay_beat = -1, delay_len = 0;
  bit holding = 1'b0;

  int stage_a [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
  int stage_b [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [2:0] load_addr(input logic [2:0] i);
`ifdef BIT_REVERSE_LOAD_EN
    return {i[0], i[1], i[2]};
`else
    return i;
`endif
  endfunction

  // One host access; a read also queues its expected data for the monitor.
  task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [15:0] data);
    @(posedge clk); #1;
    bus.host_en    = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = we ? data : 16'h0;
    if (!we) host_q.push_back(data);
    @(posedge clk); #1;
    bus.host_en = 1'b0;
    bus.host_we = 1'b0;
  endtask

  task automatic push_stage(input int s);
    pair_t p;
    for (int k = 0; k < 4; k++) begin
      p.stage = 2'(s);
      p.a     = 3'(stage_a[s][k]);
      p.b     = 3'(stage_b[s][k]);
      p.da    = model[stage_a[s][k]];
      p.db    = model[stage_b[s][k]];
      pair_q.push_back(p);
    end
  endtask

  task automatic start_pass();
    beat_idx = 0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < budget);
    checkOutput(name, 64'(bus.busy), 64'd0);
  endtask

  task automatic wait_valid(input int stg, input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.rd_valid && (stg < 0 || int'(bus.rd_stage) == stg)) && n < budget);
    checkOutput(name, 64'(bus.rd_valid), 64'd1);
  endtask

  // Monitor: host read data, operand-pair handshakes and done pulses.
  pair_t       mon_pair;
  logic [15:0] mon_host;
  always @(negedge clk) begin
    if (bus.host_rvalid) begin
      if (host_q.size() == 0) checkOutput("host_unexpected", 64'd1, 64'd0);
      else begin
        mon_host = host_q.pop_front();
        checkOutput("host_read", 64'(bus.host_rdata), 64'(mon_host));
      end
    end
    if (bus.rd_valid && bus.rd_ready) begin
      if (pair_q.size() == 0) checkOutput("pair_unexpected", 64'd1, 64'd0);
      else begin
        mon_pair = pair_q.pop_front();
        checkOutput("pair", {24'd0, bus.rd_stage, bus.rd_addr_a, bus.rd_addr_b, bus.rd_data_a, bus.rd_data_b},
                    {24'd0, mon_pair.stage, mon_pair.a, mon_pair.b, mon_pair.da, mon_pair.db});
      end
    end
    if (bus.done) done_count++;
  end

  // Consumer: every accepted pair is written back unchanged the next cycle,
  // except the designated beat, which is delayed and overwritten with 0xBEEF.
  initial begin
    wb_t item;
    bus.wb_valid  = 1'b0;
    bus.wb_addr_a = '0;
    bus.wb_addr_b = '0;
    bus.wb_data_a = '0;
    bus.wb_data_b = '0;
    forever begin
      @(negedge clk);
      holding = (wb_q.size() > 0) && (wb_q[0].delay > 0);
      if (holding) checkOutput("barrier_hold", 64'(bus.rd_valid), 64'd0);
      if (bus.rd_valid && bus.rd_ready) begin
        item.a     = bus.rd_addr_a;
        item.b     = bus.rd_addr_b;
        item.da    = bus.rd_data_a;
        item.db    = bus.rd_data_b;
        item.delay = 0;
        if (beat_idx == delay_beat) begin
          item.delay = delay_len;
          item.da    = 16'hBEEF;
          item.db    = 16'hBEEF;
        end
        wb_q.push_back(item);
        beat_idx++;
      end
      @(posedge clk); #1;
      if (wb_q.size() > 0 && wb_q[0].delay > 0) begin
        wb_q[0].delay = wb_q[0].delay - 1;
        bus.wb_valid  = 1'b0;
      end else if (wb_q.size() > 0) begin
        item          = wb_q.pop_front();
        bus.wb_valid  = 1'b1;
        bus.wb_addr_a = item.a;
        bus.wb_addr_b = item.b;
        bus.wb_data_a = item.da;
        bus.wb_data_b = item.db;
      end else begin
        bus.wb_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bus.host_en    = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.start      = 1'b0;
    bus.rd_ready   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_rvalid", 64'(bus.host_rvalid), 64'd0);
    checkOutput("reset_rdata", 64'(bus.host_rdata), 64'd0);
    rst = 1'b1;
    applyStimulus(1'b0, 3'd5, 16'h0000);
    checkOutput("idle_busy", 64'(bus.busy), 64'd0);
    checkOutput("idle_rd_valid", 64'(bus.rd_valid), 64'd0);

    // Host write/read
    applyStimulus(1'b1, load_addr(3'd3), 16'h1234);
    applyStimulus(1'b0, 3'd3, 16'h1234);

    // Full pass with straight loopback
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, load_addr(3'(i)), 16'(i));
      model[i] = 16'(i);
    end
    for (int s = 0; s < 3; s++) push_stage(s);
    bus.rd_ready = 1'b1;
    start_pass();
    wait_idle(200, "pass1_idle");
    checkOutput("pass1_done_count", 64'(done_count), 64'd1);
    checkOutput("pass1_pairs_left", 64'(pair_q.size()), 64'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 3'(i), 16'(i));

    // Backpressure on the second stage-0 pair
    for (int s = 0; s < 3; s++) push_stage(s);
    bus.rd_ready = 1'b0;
    start_pass();
    wait_valid(0, 20, "pass2_first_valid");
    @(posedge clk); #1 bus.rd_ready = 1'b1;
    @(posedge clk); #1 bus.rd_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_valid", 64'(bus.rd_valid), 64'd1);
      checkOutput("stall_addr", {58'd0, bus.rd_addr_a, bus.rd_addr_b}, {58'd0, 3'd2, 3'd3});
      checkOutput("stall_data", {32'd0, bus.rd_data_a, bus.rd_data_b}, {32'd0, 16'd2, 16'd3});
      @(posedge clk);
    end
    #1 bus.rd_ready = 1'b1;
    wait_idle(200, "pass2_idle");
    checkOutput("pass2_done_count", 64'(done_count), 64'd2);
    checkOutput("pass2_pairs_left", 64'(pair_q.size()), 64'd0);

    // Stage barrier: last stage-0 write-back delayed and carrying 0xBEEF
    push_stage(0);
    model[6] = 16'hBEEF;
    model[7] = 16'hBEEF;
    push_stage(1);
    push_stage(2);
    delay_beat = 3;
    delay_len  = 10;
    start_pass();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!holding && n < 50);
    checkOutput("pass3_holding", 64'(holding), 64'd1);
    applyStimulus(1'b1, load_addr(3'd0), 16'h5555);
    wait_idle(300, "pass3_idle");
    delay_beat = -1;
    checkOutput("pass3_done_count", 64'(done_count), 64'd3);
    checkOutput("pass3_pairs_left", 64'(pair_q.size()), 64'd0);
    applyStimulus(1'b0, 3'd6, 16'hBEEF);
    applyStimulus(1'b0, 3'd0, 16'h0000);

    // Reset in the middle of stage 1
    push_stage(0);
    push_stage(1);
    start_pass();
    wait_valid(1, 100, "pass4_stage1_valid");
    @(posedge clk); #1 bus.rd_ready = 1'b0;
    @(negedge clk);
    pair_q.delete();
    wb_q.delete();
    rst = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_rd_valid", 64'(bus.rd_valid), 64'd0);
    checkOutput("abort_done", 64'(bus.done), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_done_count", 64'(done_count), 64'd3);
    checkOutput("abort_busy_after", 64'(bus.busy), 64'd0);
    applyStimulus(1'b0, 3'd6, 16'h0000);
    applyStimulus(1'b0, 3'd2, 16'h0000);

`ifdef BIT_REVERSE_LOAD_EN
    applyStimulus(1'b1, 3'd1, 16'hAAAA);
    applyStimulus(1'b0, 3'd4, 16'hAAAA);
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("host_reads_left", 64'(host_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
